// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared state, opcode and ALU code definitions for the multicycle controller
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // alu_op selects how the ALU decoder picks its operation
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;

    // Immediate format follows the opcode alone; R-type and unknown use the I slot
    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational ALUControl decode from instruction fields and alu_op
module alu_decoder
    import riscv_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 4
) (
    input  logic [6:0]            Op,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic [1:0]            alu_op,
    output logic [ALU_CTRL_W-1:0] ALUControl
);

    logic [3:0] code;
    logic       alt;
    logic       unused_funct7;

    // Only bit 5 of funct7 distinguishes SUB/SRA from ADD/SRL
    assign alt           = funct7[5];
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // Select the ALU operation; ADDI never subtracts, only R-type honours funct7 on funct3=000
    always_comb begin
        code = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: code = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  code = (Op == OP_RTYPE && alt) ? ALU_SUB : ALU_ADD;
                    3'b001:  code = ALU_SLL;
                    3'b010:  code = ALU_SLT;
                    3'b011:  code = ALU_SLTU;
                    3'b100:  code = ALU_XOR;
                    3'b101:  code = alt ? ALU_SRA : ALU_SRL;
                    3'b110:  code = ALU_OR;
                    default: code = ALU_AND;
                endcase
            end
            default: code = ALU_ADD;
        endcase
    end

    assign ALUControl = ALU_CTRL_W'(code);

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle RISC-V main controller FSM
module multicycle_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W    = 4,
    parameter int FULL_BRANCH   = 1,
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            Op,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic                  zero,
    input  logic                  lt,
    input  logic                  ltu,
    input  logic                  mem_ready,
    output logic                  PCWrite,
    output logic                  AdrSrc,
    output logic                  IRWrite,
    output logic                  MemWrite,
    output logic                  mem_req,
    output logic                  RegWrite,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [2:0]            ImmSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic                  illegal
);

    state_t     state;
    state_t     state_next;
    logic [1:0] alu_op;
    logic       mem_ok;
    logic       branch_taken;
    logic       branch_legal;

    assign mem_ok = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign ImmSrc = imm_src_of(Op);

    alu_decoder #(
        .ALU_CTRL_W(ALU_CTRL_W)
    ) u_alu_decoder (
        .Op        (Op),
        .funct3    (funct3),
        .funct7    (funct7),
        .alu_op    (alu_op),
        .ALUControl(ALUControl)
    );

    // Branch condition from ALU flags; unsupported funct3 is never taken
    always_comb begin
        branch_taken = 1'b0;
        branch_legal = 1'b1;
        case (funct3)
            3'b000:  branch_taken = zero;
            3'b001:  branch_taken = ~zero;
            3'b100:  branch_taken = lt;
            3'b101:  branch_taken = ~lt;
            3'b110:  branch_taken = ltu;
            3'b111:  branch_taken = ~ltu;
            default: branch_legal = 1'b0;
        endcase
        if (FULL_BRANCH == 0 && funct3 != 3'b000) begin
            branch_legal = 1'b0;
        end
        if (!branch_legal) begin
            branch_taken = 1'b0;
        end
    end

    // State register; reset abandons any pending memory wait
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore outputs; PCWrite/IRWrite also follow mem_ready and branch outcome
    always_comb begin
        state_next = state;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        mem_req    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        alu_op     = ALUOP_ADD;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ok;
                PCWrite   = mem_ok;
                if (mem_ok) state_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (Op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    default: begin
                        state_next = S_FETCH;
                        illegal    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                state_next = (Op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ok) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ok) state_next = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                alu_op     = ALUOP_SUB;
                PCWrite    = branch_taken;
                illegal    = ~branch_legal;
                state_next = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                RegWrite   = 1'b1;
                PCWrite    = 1'b1;
                state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - scoreboard bench for the multicycle controller
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] Op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero, lt, ltu, mem_ready;

    logic       pcw_a, adr_a, irw_a, mw_a, mreq_a, rw_a, ill_a;
    logic [1:0] rs_a, sa_a, sb_a;
    logic [2:0] imm_a;
    logic [3:0] alu_a;
    logic       pcw_b, adr_b, irw_b, mw_b, mreq_b, rw_b, ill_b;
    logic [1:0] rs_b, sa_b, sb_b;
    logic [2:0] imm_b;
    logic [3:0] alu_b;

    logic [19:0] exp_q_a[$];
    logic [19:0] exp_q_b[$];
    int checks = 0;
    int fails  = 0;
    int cycle  = 0;

    always #5 clk = ~clk;

    multicycle_control_unit dut (
        .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .PCWrite(pcw_a), .AdrSrc(adr_a), .IRWrite(irw_a), .MemWrite(mw_a),
        .mem_req(mreq_a), .RegWrite(rw_a), .ResultSrc(rs_a), .ALUSrcA(sa_a),
        .ALUSrcB(sb_a), .ImmSrc(imm_a), .ALUControl(alu_a), .illegal(ill_a)
    );

    multicycle_control_unit #(.FULL_BRANCH(0)) dut_beq (
        .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .PCWrite(pcw_b), .AdrSrc(adr_b), .IRWrite(irw_b), .MemWrite(mw_b),
        .mem_req(mreq_b), .RegWrite(rw_b), .ResultSrc(rs_b), .ALUSrcA(sa_b),
        .ALUSrcB(sb_b), .ImmSrc(imm_b), .ALUControl(alu_b), .illegal(ill_b)
    );

    wire [19:0] act_a = {mreq_a, adr_a, irw_a, pcw_a, mw_a, rw_a, rs_a, sa_a, sb_a, imm_a, alu_a, ill_a};
    wire [19:0] act_b = {mreq_b, adr_b, irw_b, pcw_b, mw_b, rw_b, rs_b, sa_b, sb_b, imm_b, alu_b, ill_b};

    function automatic logic [19:0] pk(input logic mreq, adr, irw, pcw, mw, rw,
                                       input logic [1:0] rs, sa, sb, input logic [2:0] imm,
                                       input logic [3:0] alu, input logic ill);
        return {mreq, adr, irw, pcw, mw, rw, rs, sa, sb, imm, alu, ill};
    endfunction

    function automatic logic [2:0] imm_ref(input logic [6:0] op);
        if (op == 7'b0100011) return 3'd1;
        if (op == 7'b1100011) return 3'd2;
        if (op == 7'b1101111) return 3'd3;
        return 3'd0;
    endfunction

    function automatic bit legal_op(input logic [6:0] op);
        return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
               op == 7'b0010011 || op == 7'b1100011 || op == 7'b1101111;
    endfunction

    // Mnemonic table: ADD0 SUB1 AND2 OR3 XOR4 SLL5 SRL6 SRA7 SLT8 SLTU9
    function automatic logic [3:0] alu_ref(input bit rtype, input logic [2:0] f3, input logic [6:0] f7);
        logic [3:0] tbl[8];
        tbl = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
        if (f3 == 3'd0 && rtype && f7[5]) return 4'd1;
        if (f3 == 3'd5 && f7[5]) return 4'd7;
        return tbl[f3];
    endfunction

    // Scoreboard monitor: compare every cycle that the stimulus has described
    always @(negedge clk) begin : monitor
        logic [19:0] ea, eb;
        cycle++;
        if (exp_q_a.size() > 0) begin
            ea = exp_q_a.pop_front();
            eb = exp_q_b.pop_front();
            checks += 2;
            if (act_a !== ea) begin
                fails++;
                $display("FAIL ctrl_full cycle %0d got=%05h want=%05h", cycle, act_a, ea);
            end
            if (act_b !== eb) begin
                fails++;
                $display("FAIL ctrl_beq_only cycle %0d got=%05h want=%05h", cycle, act_b, eb);
            end
        end
    end

    task automatic cyc(input logic [19:0] ea, input logic [19:0] eb);
        exp_q_a.push_back(ea);
        exp_q_b.push_back(eb);
        @(posedge clk);
        #1;
    endtask

    // One instruction, cycle by cycle; rst_at >= 0 asserts reset during that store wait cycle
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input int fw, input int mw, input int flags, input int rst_at);
        logic [2:0]  im;
        logic [19:0] v, vb;
        logic        tk, il, tkb, ilb;
        Op = op; funct3 = f3; funct7 = f7;
        im = imm_ref(op);
        for (int i = 0; i <= fw; i++) begin
            mem_ready = (i == fw);
            v = pk(1, 0, mem_ready, mem_ready, 0, 0, 2'b10, 2'b00, 2'b10, im, 4'd0, 0);
            cyc(v, v);
        end
        mem_ready = 1'($urandom);
        v = pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, 4'd0, !legal_op(op));
        cyc(v, v);
        if (op == 7'b0000011 || op == 7'b0100011) begin
            mem_ready = 1'($urandom);
            v = pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, 4'd0, 0);
            cyc(v, v);
            for (int i = 0; i <= mw; i++) begin
                mem_ready = (i == mw);
                v = pk(1, 1, 0, 0, op == 7'b0100011, 0, 2'b00, 2'b00, 2'b00, im, 4'd0, 0);
                if (op == 7'b0100011 && i == rst_at) begin
                    rst = 1'b1;
                    cyc(v, v);
                    rst = 1'b0;
                    return;
                end
                cyc(v, v);
            end
            if (op == 7'b0000011) begin
                mem_ready = 1'($urandom);
                v = pk(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, im, 4'd0, 0);
                cyc(v, v);
            end
        end else if (op == 7'b0110011 || op == 7'b0010011) begin
            mem_ready = 1'($urandom);
            v = pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, (op == 7'b0110011) ? 2'b00 : 2'b01, im,
                   alu_ref(op == 7'b0110011, f3, f7), 0);
            cyc(v, v);
            v = pk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, 4'd0, 0);
            cyc(v, v);
        end else if (op == 7'b1100011) begin
            if (flags < 0) {zero, lt, ltu} = 3'($urandom);
            else {zero, lt, ltu} = 3'(flags);
            il = 0;
            case (f3)
                3'd0: tk = zero;
                3'd1: tk = !zero;
                3'd4: tk = lt;
                3'd5: tk = !lt;
                3'd6: tk = ltu;
                3'd7: tk = !ltu;
                default: begin tk = 0; il = 1; end
            endcase
            tkb = (f3 == 3'd0) ? zero : 1'b0;
            ilb = (f3 != 3'd0);
            v  = pk(0, 0, 0, tk,  0, 0, 2'b00, 2'b10, 2'b00, im, 4'd1, il);
            vb = pk(0, 0, 0, tkb, 0, 0, 2'b00, 2'b10, 2'b00, im, 4'd1, ilb);
            cyc(v, vb);
        end else if (op == 7'b1101111) begin
            mem_ready = 1'($urandom);
            v = pk(0, 0, 0, 1, 0, 1, 2'b00, 2'b01, 2'b10, im, 4'd0, 0);
            cyc(v, v);
        end
    endtask

    initial begin
        logic [6:0] ops[8];
        logic [6:0] op;
        logic [6:0] f7;
        int         mw, ra;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                7'b1100011, 7'b1101111, 7'b1111111, 7'b0000000};
        rst = 1'b1; Op = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
        zero = 0; lt = 0; ltu = 0; mem_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run_instr(7'b0110011, 3'd0, 7'h00, 0, 0, -1, -1);   // ADD
        run_instr(7'b0110011, 3'd0, 7'h20, 0, 0, -1, -1);   // SUB
        run_instr(7'b0010011, 3'd0, 7'h20, 0, 0, -1, -1);   // ADDI, funct7 bits set
        run_instr(7'b0000011, 3'd2, 7'h00, 0, 3, -1, -1);   // LW, 3 wait states
        run_instr(7'b1100011, 3'd1, 7'h00, 0, 0, 0, -1);    // BNE zero=0
        run_instr(7'b1100011, 3'd1, 7'h00, 0, 0, 4, -1);    // BNE zero=1
        run_instr(7'b1111111, 3'd0, 7'h00, 0, 0, -1, -1);   // illegal opcode
        run_instr(7'b0100011, 3'd2, 7'h00, 1, 5, -1, 2);    // SW aborted by reset
        run_instr(7'b1101111, 3'd0, 7'h00, 0, 0, -1, -1);   // JAL
        run_instr(7'b0100011, 3'd2, 7'h00, 0, 0, -1, -1);   // SW no wait

        for (int n = 0; n < 300; n++) begin
            op = ops[$urandom_range(0, 7)];
            if (op == 7'b0000000) op = 7'($urandom);
            case ($urandom_range(0, 2))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            mw = $urandom_range(0, 3);
            ra = ($urandom_range(0, 7) == 0) ? $urandom_range(0, mw) : -1;
            run_instr(op, 3'($urandom), f7, $urandom_range(0, 2), mw, -1, ra);
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q_a.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q_a.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
